// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Purpose  : Packs decoded SimpleRISC instruction fields into 32-bit machine
//             words, stamps each word with an instruction-memory byte address
//             and buffers it in a small FIFO drained by a valid/ready sink.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n          clock (rising edge), asynchronous active-low reset
//    in_valid/in_ready   field-bundle handshake
//    in_op .. in_off     decoded instruction fields
//    addr_load/addr_base load the address counter
//    out_valid/out_ready word handshake toward the instruction-memory writer
//    out_data/out_addr   head word and its byte address
//    err_illegal         one-cycle pulse after an illegal opcode is accepted
//    err_count           saturating illegal-opcode count
//    fifo_count          FIFO occupancy
// ============================================================================
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int ERR_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_op,
  input  logic                       in_imm_sel,
  input  logic [3:0]                 in_rd,
  input  logic [3:0]                 in_rs1,
  input  logic [3:0]                 in_rs2,
  input  logic [17:0]                in_imm,
  input  logic [26:0]                in_off,
  input  logic                       addr_load,
  input  logic [ADDR_W-1:0]          addr_base,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [ADDR_W-1:0]          out_addr,
  output logic                       err_illegal,
  output logic [ERR_W-1:0]           err_count,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;

  logic [31:0]       enc_d;
  logic              legal_d;
  logic              accept_d;
  logic              push_d;
  logic              pop_d;
  logic [ADDR_W-1:0] stamp_d;
  logic [ADDR_W-1:0] addr_d;

  logic [31:0]       mem_data_q [DEPTH];
  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ERR_W-1:0]  err_cnt_q;
  logic              err_ill_q;

  // Field packing
  always_comb begin
    enc_d   = {in_op, 27'b0};
    legal_d = 1'b1;
    case (in_op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
      5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd14, 5'd15: begin
        enc_d[26]    = in_imm_sel;
        enc_d[25:22] = in_rd;
        enc_d[21:18] = in_rs1;
        if (in_imm_sel) enc_d[17:0]  = in_imm;
        else            enc_d[17:14] = in_rs2;
        // cmp has no destination; not/mov have no first source
        if (in_op == OP_CMP)                        enc_d[25:22] = 4'b0;
        if ((in_op == OP_NOT) || (in_op == OP_MOV)) enc_d[21:18] = 4'b0;
      end
      5'd16, 5'd17, 5'd18, 5'd19: enc_d[26:0] = in_off;
      5'd13, 5'd20: ;  // nop, ret: operand field all zero
      default: legal_d = 1'b0;
    endcase
  end

  // Handshake and address stamping
  assign in_ready = rst_n & (count_q != FULL_CNT);
  assign accept_d = in_valid & in_ready;
  assign push_d   = accept_d & legal_d;
  assign pop_d    = out_valid & out_ready;

  // A load in the same cycle as a push stamps the pushed word with the base
  assign stamp_d = addr_load ? addr_base : addr_q;

  always_comb begin
    addr_d = addr_q;
    if (push_d)         addr_d = stamp_d + ADDR_W'(4);
    else if (addr_load) addr_d = addr_base;
  end

  // Storage array holds no reset: occupancy alone defines what is valid
  always_ff @(posedge clk) begin
    if (push_d) begin
      mem_data_q[wr_ptr_q] <= enc_d;
      mem_addr_q[wr_ptr_q] <= stamp_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      err_cnt_q <= '0;
      err_ill_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      err_ill_q <= accept_d & ~legal_d;
      if (accept_d && !legal_d && (err_cnt_q != {ERR_W{1'b1}}))
        err_cnt_q <= err_cnt_q + ERR_W'(1);
      if (push_d) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_d)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_d, pop_d})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head is gated so stale array contents never appear on an empty FIFO
  assign out_valid   = (count_q != '0);
  assign out_data    = out_valid ? mem_data_q[rd_ptr_q] : 32'b0;
  assign out_addr    = out_valid ? mem_addr_q[rd_ptr_q] : '0;
  assign fifo_count  = count_q;
  assign err_count   = err_cnt_q;
  assign err_illegal = err_ill_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encoder
//  Purpose  : Directed self-checking bench for instr_encoder.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int ERR_W  = 8;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_CMP = 5'b00101;
  localparam logic [4:0] OP_MOV = 5'b01001;
  localparam logic [4:0] OP_B   = 5'b10010;
  localparam logic [4:0] OP_RET = 5'b10100;
  localparam logic [4:0] OP_ILL = 5'b11000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        in_op = '0;
  logic              in_imm_sel = 1'b0;
  logic [3:0]        in_rd = '0;
  logic [3:0]        in_rs1 = '0;
  logic [3:0]        in_rs2 = '0;
  logic [17:0]       in_imm = '0;
  logic [26:0]       in_off = '0;
  logic              addr_load = 1'b0;
  logic [ADDR_W-1:0] addr_base = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              err_illegal;
  logic [ERR_W-1:0]  err_count;
  logic [2:0]        fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm_sel(in_imm_sel), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .in_off(in_off),
    .addr_load(addr_load), .addr_base(addr_base),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr),
    .err_illegal(err_illegal), .err_count(err_count), .fifo_count(fifo_count)
  );

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic set_fields(input logic [4:0] op, input logic isel,
                            input logic [3:0] rd, input logic [3:0] rs1,
                            input logic [3:0] rs2, input logic [17:0] imm,
                            input logic [26:0] off);
    in_op = op; in_imm_sel = isel; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_imm = imm; in_off = off;
  endtask

  // One bundle, one accepting edge; returns on the following falling edge
  task automatic send(input logic [4:0] op, input logic isel,
                      input logic [3:0] rd, input logic [3:0] rs1,
                      input logic [3:0] rs2, input logic [17:0] imm,
                      input logic [26:0] off);
    @(negedge clk);
    set_fields(op, isel, rd, rs1, rs2, imm, off);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d, expected 0", fifo_count); end
    n_checks++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL reset_err_count: got %h, expected 00", err_count); end
    n_checks++; if ({out_data, out_addr, err_illegal} !== 65'b0) begin n_fail++; $display("FAIL reset_outputs: got data %h addr %h err %b, expected all 0", out_data, out_addr, err_illegal); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b, expected 1", in_ready); end
  endtask

  task automatic test_basic();
    send(OP_ADD, 1'b0, 4'd1, 4'd2, 4'd3, 18'h0, 27'h0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b, expected 1", out_valid); end
    n_checks++; if (out_data !== 32'h0048C000) begin n_fail++; $display("FAIL basic_data: got %h, expected 0048C000", out_data); end
    n_checks++; if (out_addr !== 32'h0) begin n_fail++; $display("FAIL basic_addr: got %h, expected 0", out_addr); end
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL basic_count: got %0d, expected 1", fifo_count); end
    @(negedge clk);  // unaccepted word must hold
    n_checks++; if (out_data !== 32'h0048C000) begin n_fail++; $display("FAIL basic_hold: got %h, expected 0048C000", out_data); end
    pop_one();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %b, expected 0", out_valid); end
  endtask

  task automatic test_immediate();
    send(OP_MOV, 1'b1, 4'd5, 4'd7, 4'd0, 18'h0000A, 27'h0);
    n_checks++; if (out_data !== 32'h4D40000A) begin n_fail++; $display("FAIL imm_data: got %h, expected 4D40000A", out_data); end
    n_checks++; if (out_addr !== 32'h4) begin n_fail++; $display("FAIL imm_addr: got %h, expected 4", out_addr); end
    pop_one();
  endtask

  task automatic test_branch_ret_cmp();
    send(OP_B,   1'b1, 4'hF, 4'hF, 4'hF, 18'h3FFFF, 27'h7FFFFFF);
    send(OP_RET, 1'b1, 4'hA, 4'h5, 4'h3, 18'h12345, 27'h5555555);
    send(OP_CMP, 1'b0, 4'd7, 4'd1, 4'd2, 18'h0, 27'h0);
    n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL br_count: got %0d, expected 3", fifo_count); end
    n_checks++; if (out_data !== 32'h97FFFFFF || out_addr !== 32'h8) begin n_fail++; $display("FAIL br_b: got %h@%h, expected 97FFFFFF@8", out_data, out_addr); end
    pop_one();
    n_checks++; if (out_data !== 32'hA0000000 || out_addr !== 32'hC) begin n_fail++; $display("FAIL br_ret: got %h@%h, expected A0000000@C", out_data, out_addr); end
    pop_one();
    n_checks++; if (out_data !== 32'h28048000 || out_addr !== 32'h10) begin n_fail++; $display("FAIL br_cmp: got %h@%h, expected 28048000@10", out_data, out_addr); end
    pop_one();
  endtask

  task automatic test_illegal();
    send(OP_ILL, 1'b0, 4'd1, 4'd1, 4'd1, 18'h0, 27'h0);
    n_checks++; if (err_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_pulse: got %b, expected 1", err_illegal); end
    n_checks++; if (err_count !== 8'h01) begin n_fail++; $display("FAIL ill_count: got %h, expected 01", err_count); end
    n_checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL ill_nowrite: got valid %b count %0d, expected 0/0", out_valid, fifo_count); end
    @(negedge clk);
    n_checks++; if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL ill_pulse_end: got %b, expected 0", err_illegal); end
    send(OP_ADD, 1'b0, 4'd1, 4'd2, 4'd3, 18'h0, 27'h0);
    n_checks++; if (out_addr !== 32'h14) begin n_fail++; $display("FAIL ill_addr_hold: got %h, expected 14", out_addr); end
    pop_one();
    // 255 more back-to-back illegal accepts -> 256 total
    @(negedge clk);
    set_fields(OP_ILL, 1'b0, 4'd0, 4'd0, 4'd0, 18'h0, 27'h0);
    in_valid = 1'b1;
    repeat (255) @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (err_count !== 8'hFF) begin n_fail++; $display("FAIL ill_saturate: got %h, expected FF", err_count); end
    send(OP_ILL, 1'b0, 4'd0, 4'd0, 4'd0, 18'h0, 27'h0);
    n_checks++; if (err_count !== 8'hFF) begin n_fail++; $display("FAIL ill_sat_hold: got %h, expected FF", err_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    n_checks++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL bp_err_cleared: got %h, expected 00", err_count); end
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_%0d: got %b, expected 1", i, in_ready); end
      set_fields(OP_ADD, 1'b0, 4'(i + 1), 4'd0, 4'd0, 18'h0, 27'h0);
      in_valid = 1'b1;
    end
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0 || fifo_count !== 3'd4) begin n_fail++; $display("FAIL bp_full: got ready %b count %0d, expected 0/4", in_ready, fifo_count); end
    set_fields(OP_ADD, 1'b0, 4'd5, 4'd0, 4'd0, 18'h0, 27'h0);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0 || fifo_count !== 3'd4) begin n_fail++; $display("FAIL bp_stall: got ready %b count %0d, expected 0/4", in_ready, fifo_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== (32'(i + 1) << 22) || out_addr !== 32'(i * 4)) begin
        n_fail++;
        $display("FAIL bp_drain_%0d: got v%b %h@%h, expected v1 %h@%h", i, out_valid, out_data, out_addr, 32'(i + 1) << 22, 32'(i * 4));
      end
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b, expected 0", out_valid); end
    // address load coinciding with an accept
    @(negedge clk);
    addr_load = 1'b1;
    addr_base = 32'h100;
    set_fields(OP_ADD, 1'b0, 4'd9, 4'd0, 4'd0, 18'h0, 27'h0);
    in_valid = 1'b1;
    @(negedge clk);
    addr_load = 1'b0;
    set_fields(OP_ADD, 1'b0, 4'd10, 4'd0, 4'd0, 18'h0, 27'h0);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL load_count: got %0d, expected 2", fifo_count); end
    n_checks++; if (out_data !== 32'h02400000 || out_addr !== 32'h100) begin n_fail++; $display("FAIL load_first: got %h@%h, expected 02400000@100", out_data, out_addr); end
    pop_one();
    n_checks++; if (out_data !== 32'h02800000 || out_addr !== 32'h104) begin n_fail++; $display("FAIL load_second: got %h@%h, expected 02800000@104", out_data, out_addr); end
    pop_one();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    send(OP_ADD, 1'b0, 4'd1, 4'd0, 4'd0, 18'h0, 27'h0);
    send(OP_ADD, 1'b0, 4'd2, 4'd0, 4'd0, 18'h0, 27'h0);
    send(OP_ADD, 1'b0, 4'd3, 4'd0, 4'd0, 18'h0, 27'h0);
    send(OP_ILL, 1'b0, 4'd0, 4'd0, 4'd0, 18'h0, 27'h0);
    n_checks++; if (fifo_count !== 3'd3 || err_count !== 8'h01) begin n_fail++; $display("FAIL mr_setup: got count %0d err %h, expected 3/01", fifo_count, err_count); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0 || err_count !== 8'h00 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mr_async: got v%b c%0d e%h r%b, expected all 0", out_valid, fifo_count, err_count, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    send(OP_ADD, 1'b0, 4'd2, 4'd0, 4'd0, 18'h0, 27'h0);
    n_checks++; if (out_data !== 32'h00800000 || out_addr !== 32'h0 || fifo_count !== 3'd1) begin n_fail++; $display("FAIL mr_restart: got %h@%h c%0d, expected 00800000@0 c1", out_data, out_addr, fifo_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_immediate();
    test_branch_ret_cmp();
    test_illegal();
    test_backpressure();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
